// File: rtl/digit_scanner.sv
// digit_scanner
//   Time-multiplexes an 8-digit hex value onto a common-segment seven-segment
//   display. One digit is shown per scan slot. Input data is held in shadow
//   registers that are refreshed only at frame boundaries, so a frame never
//   mixes old and new digits.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined   : digit i shows only if enabled and some nibble at index >= i
//                 is nonzero (digit 0 needs only its enable)
//     undefined : digit i shows iff its enable bit is set
//
// Ports
//   sysclk      in   1   system clock, rising edge
//   reset       in   1   synchronous active-high reset
//   value       in  32   nibble i is digit i
//   dp          in   8   decimal point per digit
//   digit_en    in   8   per-digit enable, 0 blanks the digit
//   load        in   1   request a shadow update at the next frame edge
//   load_ack    out  1   one-cycle pulse, shadows updated
//   anodes      out  8   one-hot digit select (0 when blanked)
//   segments    out  8   bit0=a .. bit6=g, bit7=dp
//   frame_start out  1   one-cycle pulse as digit 0's slot begins
module digit_scanner #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 100000
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic [7:0]  dp,
   input  logic [7:0]  digit_en,
   input  logic        load,
   output logic        load_ack,
   output logic [7:0]  anodes,
   output logic [7:0]  segments,
   output logic        frame_start
);

   localparam int              DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);

   // Seven-segment pattern, gfedcba
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h3F;
         4'h1:    pat = 7'h06;
         4'h2:    pat = 7'h5B;
         4'h3:    pat = 7'h4F;
         4'h4:    pat = 7'h66;
         4'h5:    pat = 7'h6D;
         4'h6:    pat = 7'h7D;
         4'h7:    pat = 7'h07;
         4'h8:    pat = 7'h7F;
         4'h9:    pat = 7'h6F;
         4'hA:    pat = 7'h77;
         4'hB:    pat = 7'h7C;
         4'hC:    pat = 7'h39;
         4'hD:    pat = 7'h5E;
         4'hE:    pat = 7'h79;
         4'hF:    pat = 7'h71;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

   logic [DIV_W-1:0] div_cnt_r;
   logic [2:0]       idx_r;
   logic             pending_r;
   logic [31:0]      value_sh_r;
   logic [7:0]       dp_sh_r;
   logic [7:0]       en_sh_r;
   logic             load_ack_r;
   logic             frame_start_r;
   logic [7:0]       anodes_r;
   logic [7:0]       segments_r;

   logic             slot_edge_s;
   logic             frame_edge_s;
   logic             capture_s;
   logic [3:0]       nibble_s;
   logic             show_s;
   logic [7:0]       anodes_nxt_s;
   logic [7:0]       segments_nxt_s;

   // Slot/frame edge decode and capture decision
   always_comb begin
      slot_edge_s  = (div_cnt_r == DIV_LAST);
      frame_edge_s = slot_edge_s && (idx_r == IDX_LAST);
      // a load arriving on the frame edge itself is captured immediately
      capture_s    = frame_edge_s && (pending_r || load);
      nibble_s     = value_sh_r[{idx_r, 2'b00} +: 4];
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [7:0] nz_above_s;
   logic       nz_acc_s;

   // nz_above_s[i]: some nibble at index >= i is nonzero
   always_comb begin
      nz_above_s = 8'h00;
      nz_acc_s   = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         nz_acc_s      = nz_acc_s | (value_sh_r[4*i +: 4] != 4'h0);
         nz_above_s[i] = nz_acc_s;
      end
   end

   // Digit visibility with leading-zero suppression (digit 0 exempt)
   always_comb begin
      show_s = en_sh_r[idx_r] && ((idx_r == 3'd0) || nz_above_s[idx_r]);
   end
`else
   // Digit visibility from the enable mask alone
   always_comb begin
      show_s = en_sh_r[idx_r];
   end
`endif

   // Next output pattern for the current slot
   always_comb begin
      anodes_nxt_s   = 8'h00;
      segments_nxt_s = 8'h00;
      if (show_s) begin
         anodes_nxt_s   = 8'h01 << idx_r;
         segments_nxt_s = {dp_sh_r[idx_r], hex7(nibble_s)};
      end else begin
         anodes_nxt_s   = 8'h00;
         segments_nxt_s = 8'h00;
      end
   end

   // Slot divider and digit index
   always_ff @(posedge sysclk) begin
      if (reset) begin
         div_cnt_r <= '0;
         idx_r     <= 3'd0;
      end else if (slot_edge_s) begin
         div_cnt_r <= '0;
         if (idx_r == IDX_LAST) begin
            idx_r <= 3'd0;
         end else begin
            idx_r <= idx_r + 3'd1;
         end
      end else begin
         div_cnt_r <= div_cnt_r + 1'b1;
      end
   end

   // Load handshake and shadow registers
   always_ff @(posedge sysclk) begin
      if (reset) begin
         pending_r     <= 1'b0;
         value_sh_r    <= 32'h0000_0000;
         dp_sh_r       <= 8'h00;
         en_sh_r       <= 8'h00;
         load_ack_r    <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         load_ack_r    <= capture_s;
         frame_start_r <= frame_edge_s;
         if (capture_s) begin
            pending_r  <= 1'b0;
            value_sh_r <= value;
            dp_sh_r    <= dp;
            en_sh_r    <= digit_en;
         end else if (load) begin
            pending_r  <= 1'b1;
         end
      end
   end

   // Registered display outputs, one cycle behind idx/shadows
   always_ff @(posedge sysclk) begin
      if (reset) begin
         anodes_r   <= 8'h00;
         segments_r <= 8'h00;
      end else begin
         anodes_r   <= anodes_nxt_s;
         segments_r <= segments_nxt_s;
      end
   end

   assign load_ack    = load_ack_r;
   assign frame_start = frame_start_r;
   assign anodes      = anodes_r;
   assign segments    = segments_r;

endmodule

// File: tb/tb_digit_scanner.sv
module tb_digit_scanner;

   logic        sysclk = 1'b0;
   logic        reset;
   logic [31:0] value;
   logic [7:0]  dp;
   logic [7:0]  digit_en;
   logic        load;
   logic        load_ack;
   logic [7:0]  anodes;
   logic [7:0]  segments;
   logic        frame_start;

   int total = 0;
   int bad   = 0;
   int acks  = 0;
   logic nonblank = 1'b0;

   digit_scanner #(.NUM_DIGITS(8), .SCAN_DIV(32)) dut (
      .sysclk(sysclk), .reset(reset), .value(value), .dp(dp),
      .digit_en(digit_en), .load(load), .load_ack(load_ack),
      .anodes(anodes), .segments(segments), .frame_start(frame_start)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] value;
      logic [7:0]  dp;
      logic [7:0]  en;
      logic [63:0] exp_an;   // slot k in bits [8k+7:8k]
      logic [63:0] exp_seg;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic sample();
      @(negedge sysclk);
      if (load_ack) acks++;
      if (anodes != 8'h00 || segments != 8'h00) nonblank = 1'b1;
   endtask

   // waits for the frame_start sample; n = samples taken
   task automatic wait_fs(input int max, output int n);
      n = 0;
      do begin
         sample();
         n++;
      end while (!frame_start && n < max);
   endtask

   // check slots k0..k1 starting from a frame_start sample; every cycle of a slot must match
   task automatic check_slots(input int vi, input int k0, input int k1);
      logic [15:0] act;
      logic [15:0] exp;
      for (int k = k0; k <= k1; k++) begin
         exp = {vecs[vi].exp_an[8*k +: 8], vecs[vi].exp_seg[8*k +: 8]};
         act = 16'h0000;
         for (int c = 0; c < 32; c++) begin
            sample();
            load = 1'b0;
            if (c == 0) act = {anodes, segments};
            else if (act == exp) act = {anodes, segments};
         end
         chk($sformatf("vec%0d_slot%0d", vi, k), {16'h0000, act}, {16'h0000, exp});
      end
   endtask

   task automatic do_vec(input int vi);
      int n;
      repeat (100) sample();
      value    = vecs[vi].value;
      dp       = vecs[vi].dp;
      digit_en = vecs[vi].en;
      acks     = 0;
      load     = 1'b1;
      sample();
      load     = 1'b0;
      wait_fs(300, n);
      chk($sformatf("vec%0d_fs", vi), {31'd0, frame_start}, 32'd1);
      chk($sformatf("vec%0d_ack_with_fs", vi), {31'd0, load_ack}, 32'd1);
      chk($sformatf("vec%0d_ack_count", vi), acks, 32'd1);
      check_slots(vi, 0, 7);
   endtask

   initial begin
      int n;
      // digit 0 of 1234_5678 is '8' (7F) with dp set -> FF
      vecs[0] = '{32'h1234_5678, 8'h01, 8'hFF, 64'h8040_2010_0804_0201, 64'h065B_4F66_6D7D_07FF};
      vecs[1] = '{32'hFFFF_FFFF, 8'h00, 8'h0F, 64'h0000_0000_0804_0201, 64'h0000_0000_7171_7171};
`ifdef LEADING_ZERO_BLANK_EN
      vecs[2] = '{32'h0000_00A5, 8'h00, 8'hFF, 64'h0000_0000_0000_0201, 64'h0000_0000_0000_776D};
      vecs[3] = '{32'h0000_0000, 8'h00, 8'hFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_003F};
`else
      vecs[2] = '{32'h0000_00A5, 8'h00, 8'hFF, 64'h8040_2010_0804_0201, 64'h3F3F_3F3F_3F3F_776D};
      vecs[3] = '{32'h0000_0000, 8'h00, 8'hFF, 64'h8040_2010_0804_0201, 64'h3F3F_3F3F_3F3F_3F3F};
`endif
      vecs[4] = '{32'h89AB_CDEF, 8'hA5, 8'hFF, 64'h8040_2010_0804_0201, 64'hFF6F_F77C_39DE_79F1};
      vecs[5] = '{32'h1234_5678, 8'hFF, 8'h00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

      // reset state, then idle scanning with empty shadows
      reset = 1'b1; value = 32'h0; dp = 8'h0; digit_en = 8'h0; load = 1'b0;
      repeat (3) sample();
      chk("rst_anodes", {24'd0, anodes}, 32'h0);
      chk("rst_segments", {24'd0, segments}, 32'h0);
      chk("rst_load_ack", {31'd0, load_ack}, 32'h0);
      chk("rst_frame_start", {31'd0, frame_start}, 32'h0);
      reset = 1'b0; acks = 0; nonblank = 1'b0;
      wait_fs(300, n);
      chk("first_frame_delay", n, 32'd256);
      wait_fs(300, n);
      chk("frame_period", n, 32'd256);
      chk("idle_blank", {31'd0, nonblank}, 32'h0);
      chk("idle_no_ack", acks, 32'h0);

      for (int i = 0; i < 6; i++) do_vec(i);

      // value change without load leaves the display alone
      do_vec(0);
      value = 32'hFFFF_FFFF;
      check_slots(0, 0, 7);

      // mid-frame load (two pulses) takes effect only at the next frame
      acks = 0;
      check_slots(0, 0, 3);
      value = 32'h0000_00A5; dp = 8'h00; digit_en = 8'hFF; load = 1'b1;
      check_slots(0, 4, 5);
      load = 1'b1;
      check_slots(0, 6, 7);
      chk("midload_fs", {31'd0, frame_start}, 32'd1);
      chk("midload_ack_with_fs", {31'd0, load_ack}, 32'd1);
      chk("midload_ack_at_frame", acks, 32'd1);
      check_slots(2, 0, 7);
      chk("midload_single_ack", acks, 32'd1);

      // reset with a pending load: no ack, blank outputs, scan restarts
      value = 32'h1234_5678; dp = 8'h01; digit_en = 8'hFF; load = 1'b1;
      sample();
      load = 1'b0;
      repeat (10) sample();
      reset = 1'b1;
      sample();
      chk("rst2_anodes", {24'd0, anodes}, 32'h0);
      chk("rst2_segments", {24'd0, segments}, 32'h0);
      chk("rst2_load_ack", {31'd0, load_ack}, 32'h0);
      reset = 1'b0; acks = 0; nonblank = 1'b0;
      wait_fs(300, n);
      chk("rst2_restart_delay", n, 32'd256);
      repeat (40) sample();
      chk("rst2_no_ack", acks, 32'h0);
      chk("rst2_blank", {31'd0, nonblank}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
